// File: rtl/led_pulse_stretcher_pkg.sv
// Shared board constants and the per-channel state encoding for the LED pulse stretcher.
package led_pulse_stretcher_pkg;

  localparam int BOARD_CLK_HZ    = 50_000_000;
  localparam int BOARD_LED_COUNT = 4;

  localparam int DEFAULT_ON_CLOCKS  = 256;
  localparam int DEFAULT_OFF_CLOCKS = 256;
  localparam int DEFAULT_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } chan_state_t;

endpackage

// File: rtl/led_pulse_stretcher_channel.sv
// One stretcher channel: fixed-length high pulse, enforced low gap, and a single
// pending flag that folds any strobes seen while busy into one follow-on pulse.
module led_pulse_channel
  import led_pulse_stretcher_pkg::*;
#(
  parameter int ON_CLOCKS  = DEFAULT_ON_CLOCKS,
  parameter int OFF_CLOCKS = DEFAULT_OFF_CLOCKS,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic resetn,
  input  logic strobe,
  output logic dout,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] ON_LAST  = CNT_WIDTH'(ON_CLOCKS - 1);
  localparam logic [CNT_WIDTH-1:0] OFF_LAST = CNT_WIDTH'(OFF_CLOCKS - 1);

  chan_state_t          state_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 pending_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      pending_reg <= 1'b0;
      dout        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (strobe) begin
            state_reg <= ON;
            count_reg <= '0;
            dout      <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ON: begin
          // A strobe here only queues a follow-on pulse; the current one is not restarted.
          if (strobe) pending_reg <= 1'b1;
          if (count_reg == ON_LAST) begin
            state_reg <= GAP;
            count_reg <= '0;
            dout      <= 1'b0;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        GAP: begin
          if (count_reg == OFF_LAST) begin
            count_reg   <= '0;
            pending_reg <= 1'b0;
            if (pending_reg || strobe) begin
              state_reg <= ON;
              dout      <= 1'b1;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end else begin
            count_reg <= count_reg + 1'b1;
            if (strobe) pending_reg <= 1'b1;
          end
        end

        default: begin
          state_reg   <= IDLE;
          count_reg   <= '0;
          pending_reg <= 1'b0;
          dout        <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Multi-channel LED pulse stretcher: WIDTH independent copies of led_pulse_channel.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int ON_CLOCKS  = DEFAULT_ON_CLOCKS,
  parameter int OFF_CLOCKS = DEFAULT_OFF_CLOCKS,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] strobe,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] busy
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    led_pulse_channel #(
      .ON_CLOCKS (ON_CLOCKS),
      .OFF_CLOCKS(OFF_CLOCKS),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan (
      .clk   (clk),
      .resetn(resetn),
      .strobe(strobe[gi]),
      .dout  (dout[gi]),
      .busy  (busy[gi])
    );
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Bench for led_pulse_stretcher (2 channels, 4 on / 3 off): a timeline model plus
// hand-computed per-cycle expectations for each directed scenario.
module tb_led_pulse_stretcher;

  localparam int W   = 2;
  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int CW  = 2;

  logic         clk    = 1'b0;
  logic         resetn = 1'b1;
  logic [W-1:0] strobe = '0;
  logic [W-1:0] dout;
  logic [W-1:0] busy;

  int checks   = 0;
  int failures = 0;

  int edge_cnt  = 0;
  int scen_base = 0;

  // Model: each channel is either inactive, or carries the edge index at which
  // its current pulse was accepted; pulse is high for ON edges after that point.
  int m_start  [W];
  bit m_active [W];
  bit m_pend   [W];

  bit         sched0    [0:63];
  bit         sched1    [0:63];
  logic [1:0] hist_dout [0:79];
  logic [1:0] hist_busy [0:79];

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .WIDTH     (W),
    .ON_CLOCKS (ON),
    .OFF_CLOCKS(OFF),
    .CNT_WIDTH (CW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .strobe(strobe),
    .dout  (dout),
    .busy  (busy)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int ch = 0; ch < W; ch++) begin
        m_active[ch] <= 1'b0;
        m_pend[ch]   <= 1'b0;
        m_start[ch]  <= 0;
      end
    end else begin
      for (int ch = 0; ch < W; ch++) begin
        if (!m_active[ch]) begin
          if (strobe[ch]) begin
            m_active[ch] <= 1'b1;
            m_start[ch]  <= edge_cnt;
          end
        end else if (edge_cnt - m_start[ch] == ON + OFF) begin
          if (m_pend[ch] || strobe[ch]) m_start[ch] <= edge_cnt;
          else m_active[ch] <= 1'b0;
          m_pend[ch] <= 1'b0;
        end else if (strobe[ch]) begin
          m_pend[ch] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int age;
    int cyc;
    for (int ch = 0; ch < W; ch++) begin
      age = edge_cnt - 1 - m_start[ch];
      check_bit($sformatf("model_dout ch%0d edge%0d", ch, edge_cnt), dout[ch],
                m_active[ch] && (age < ON));
      check_bit($sformatf("model_busy ch%0d edge%0d", ch, edge_cnt), busy[ch], m_active[ch]);
    end
    cyc = edge_cnt - scen_base + 1;
    if (cyc >= 0 && cyc < 80) begin
      hist_dout[cyc] <= dout;
      hist_busy[cyc] <= busy;
    end
  end

  task automatic clear_sched();
    for (int k = 0; k < 64; k++) begin
      sched0[k] = 1'b0;
      sched1[k] = 1'b0;
    end
  endtask

  // Leaves the bench 1 time unit after a falling edge with a fresh scenario base.
  task automatic do_reset();
    @(negedge clk);
    #1;
    resetn = 1'b0;
    strobe = '0;
    repeat (2) @(negedge clk);
    #1;
    resetn    = 1'b1;
    scen_base = edge_cnt;
  endtask

  // Edge k of the scenario samples {sched1[k], sched0[k]}; its result is cycle k+1.
  task automatic run(input int n);
    for (int k = 1; k <= n; k++) begin
      strobe = {sched1[k], sched0[k]};
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    strobe = '0;
  endtask

  task automatic expect_range(input string name, input int ch, input bit is_busy,
                              input int from, input int to, input logic val);
    for (int c = from; c <= to; c++) begin
      check_bit($sformatf("%s ch%0d cycle%0d", name, ch, c),
                is_busy ? hist_busy[c][ch] : hist_dout[c][ch], val);
    end
  endtask

  initial begin
    #1;
    resetn = 1'b0;
    @(negedge clk);
    #1;
    check_bit("reset_state dout0", dout[0], 1'b0);
    check_bit("reset_state busy0", busy[0], 1'b0);
    check_bit("reset_state dout1", dout[1], 1'b0);
    check_bit("reset_state busy1", busy[1], 1'b0);

    // Single strobe at edge 10
    do_reset();
    clear_sched();
    sched0[10] = 1'b1;
    run(25);
    expect_range("single_dout", 0, 1'b0, 2, 10, 1'b0);
    expect_range("single_dout", 0, 1'b0, 11, 14, 1'b1);
    expect_range("single_dout", 0, 1'b0, 15, 25, 1'b0);
    expect_range("single_busy", 0, 1'b1, 11, 17, 1'b1);
    expect_range("single_busy", 0, 1'b1, 18, 25, 1'b0);

    // Collapsed strobes at edges 10, 12, 13
    do_reset();
    clear_sched();
    sched0[10] = 1'b1;
    sched0[12] = 1'b1;
    sched0[13] = 1'b1;
    run(35);
    expect_range("collapse_dout", 0, 1'b0, 11, 14, 1'b1);
    expect_range("collapse_dout", 0, 1'b0, 15, 17, 1'b0);
    expect_range("collapse_dout", 0, 1'b0, 18, 21, 1'b1);
    expect_range("collapse_dout", 0, 1'b0, 22, 35, 1'b0);
    expect_range("collapse_busy", 0, 1'b1, 25, 35, 1'b0);

    // Held strobe, edges 10..39
    do_reset();
    clear_sched();
    for (int k = 10; k <= 39; k++) sched0[k] = 1'b1;
    run(50);
    check_bit("held_dout ch0 cycle10", hist_dout[10][0], 1'b0);
    for (int c = 11; c <= 38; c++)
      check_bit($sformatf("held_dout ch0 cycle%0d", c), hist_dout[c][0], ((c - 11) % 7) < 4);

    // Strobe on the final GAP edge
    do_reset();
    clear_sched();
    sched0[10] = 1'b1;
    sched0[17] = 1'b1;
    run(30);
    expect_range("lastgap_dout", 0, 1'b0, 15, 17, 1'b0);
    expect_range("lastgap_dout", 0, 1'b0, 18, 21, 1'b1);
    expect_range("lastgap_busy", 0, 1'b1, 11, 24, 1'b1);
    expect_range("lastgap_busy", 0, 1'b1, 25, 30, 1'b0);

    // Reset during a pulse with a follow-on already pending
    do_reset();
    clear_sched();
    sched0[10] = 1'b1;
    sched0[11] = 1'b1;
    run(11);
    check_bit("midreset_pre dout0", dout[0], 1'b1);
    resetn = 1'b0;
    #1;
    check_bit("midreset_async dout0", dout[0], 1'b0);
    check_bit("midreset_async busy0", busy[0], 1'b0);
    strobe = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check_bit("midreset_ignored dout0", dout[0], 1'b0);
    check_bit("midreset_ignored busy1", busy[1], 1'b0);
    strobe    = '0;
    resetn    = 1'b1;
    scen_base = edge_cnt;
    clear_sched();
    sched0[3] = 1'b1;
    run(20);
    expect_range("postreset_dout", 0, 1'b0, 2, 3, 1'b0);
    expect_range("postreset_dout", 0, 1'b0, 4, 7, 1'b1);
    expect_range("postreset_dout", 0, 1'b0, 8, 20, 1'b0);
    expect_range("postreset_busy", 0, 1'b1, 4, 10, 1'b1);
    expect_range("postreset_busy", 0, 1'b1, 11, 20, 1'b0);

    // Channel 1 strobed while channel 0 is in its gap
    do_reset();
    clear_sched();
    sched0[10] = 1'b1;
    sched1[15] = 1'b1;
    run(30);
    expect_range("indep_dout", 0, 1'b0, 11, 14, 1'b1);
    expect_range("indep_dout", 0, 1'b0, 15, 30, 1'b0);
    expect_range("indep_busy", 0, 1'b1, 11, 17, 1'b1);
    expect_range("indep_busy", 0, 1'b1, 18, 30, 1'b0);
    expect_range("indep_dout", 1, 1'b0, 2, 15, 1'b0);
    expect_range("indep_dout", 1, 1'b0, 16, 19, 1'b1);
    expect_range("indep_dout", 1, 1'b0, 20, 30, 1'b0);
    expect_range("indep_busy", 1, 1'b1, 16, 22, 1'b1);
    expect_range("indep_busy", 1, 1'b1, 23, 30, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
